// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the MIPS E stage with a fixed-latency busy counter.
// Build option: define MDU_DIV_EN to include div/divu; otherwise they are no-ops.
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  order,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [6:0] ORD_MFHI  = 7'h10;
  localparam logic [6:0] ORD_MTHI  = 7'h11;
  localparam logic [6:0] ORD_MFLO  = 7'h12;
  localparam logic [6:0] ORD_MTLO  = 7'h13;
  localparam logic [6:0] ORD_MULT  = 7'h18;
  localparam logic [6:0] ORD_MULTU = 7'h19;
  localparam logic [6:0] ORD_DIV   = 7'h1a;
  localparam logic [6:0] ORD_DIVU  = 7'h1b;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [63:0]      pend, pend_next;
  logic [31:0]      hi_next, lo_next;
  logic [63:0]      prod_s, prod_u;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

`ifdef MDU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);

  // Divide results are packed {remainder, quotient} to match {hi, lo}.
  logic [63:0]        div_s, div_u;
  logic               div_zero, div_ovf;
  logic [31:0]        dvs_s, dvs_u;
  logic signed [31:0] q_s, r_s;

  assign div_zero = (rt_val == 32'h0);
  assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hffff_ffff);
  // Corner cases get a harmless divisor so the arithmetic never sees /0 or overflow.
  assign dvs_s    = (div_zero || div_ovf) ? 32'd1 : rt_val;
  assign dvs_u    = div_zero ? 32'd1 : rt_val;

  always_comb begin
    q_s = $signed(rs_val) / $signed(dvs_s);
    r_s = $signed(rs_val) % $signed(dvs_s);
    if (div_zero)     div_s = {rs_val, 32'hffff_ffff};
    else if (div_ovf) div_s = {32'h0, 32'h8000_0000};
    else              div_s = {r_s, q_s};
    if (div_zero)     div_u = {rs_val, 32'hffff_ffff};
    else              div_u = {rs_val % dvs_u, rs_val / dvs_u};
  end
`endif

  always_comb begin
    cnt_next  = cnt;
    pend_next = pend;
    hi_next   = hi;
    lo_next   = lo;
    if (cnt != '0) begin
      cnt_next = cnt - 1'b1;
      if (cnt == CNT_W'(1)) {hi_next, lo_next} = pend;
    end else if (start) begin
      case (order)
        ORD_MULT:  begin pend_next = prod_s; cnt_next = MULT_LAT; end
        ORD_MULTU: begin pend_next = prod_u; cnt_next = MULT_LAT; end
`ifdef MDU_DIV_EN
        ORD_DIV:   begin pend_next = div_s;  cnt_next = DIV_LAT;  end
        ORD_DIVU:  begin pend_next = div_u;  cnt_next = DIV_LAT;  end
`endif
        ORD_MTHI:  hi_next = rs_val;
        ORD_MTLO:  lo_next = rs_val;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      pend <= '0;
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      pend <= pend_next;
      hi   <= hi_next;
      lo   <= lo_next;
      busy <= (cnt_next != '0);
    end
  end

  always_comb begin
    md_out = 32'h0;
    if (order == ORD_MFHI)      md_out = hi;
    else if (order == ORD_MFLO) md_out = lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic reference model checked every cycle,
// plus hand-computed literal expectations. Honours MDU_DIV_EN like the design.
`timescale 1ns/1ps
module tb_mult_div_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [6:0] OP_NOP   = 7'h00;
  localparam logic [6:0] OP_MFHI  = 7'h10;
  localparam logic [6:0] OP_MTHI  = 7'h11;
  localparam logic [6:0] OP_MFLO  = 7'h12;
  localparam logic [6:0] OP_MTLO  = 7'h13;
  localparam logic [6:0] OP_MULT  = 7'h18;
  localparam logic [6:0] OP_MULTU = 7'h19;
  localparam logic [6:0] OP_DIV   = 7'h1a;
  localparam logic [6:0] OP_DIVU  = 7'h1b;

`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  order = OP_NOP;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] rt_val = 32'h0;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .order(order),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
  logic [63:0] m_pend = 64'h0;
  bit          m_busy = 1'b0;
  int          e_cnt = 0, m_done = 0;

  function automatic int latency(input logic [6:0] op);
    if (op == OP_MULT || op == OP_MULTU) return MULT_CYCLES;
    if (DIV_ON && (op == OP_DIV || op == OP_DIVU)) return DIV_CYCLES;
    return 0;
  endfunction

  function automatic logic [63:0] model_result(input logic [6:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hffff_ffff};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'h0) return {a, 32'hffff_ffff};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default:  return 64'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 32'h0; m_lo = 32'h0; m_busy = 1'b0; e_cnt = 0; m_done = 0;
    end else begin
      e_cnt++;
      if (m_busy) begin
        if (e_cnt == m_done) begin
          {m_hi, m_lo} = m_pend;
          m_busy = 1'b0;
        end
      end else if (start) begin
        if (latency(order) != 0) begin
          m_pend = model_result(order, rs_val, rt_val);
          m_done = e_cnt + latency(order);
          m_busy = 1'b1;
        end else if (order == OP_MTHI) m_hi = rs_val;
        else if (order == OP_MTLO)     m_lo = rs_val;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_md;
    exp_md = (order == OP_MFHI) ? m_hi : (order == OP_MFLO) ? m_lo : 32'h0;
    check("cmp_busy", {31'h0, busy}, {31'h0, m_busy});
    check("cmp_hi", hi, m_hi);
    check("cmp_lo", lo, m_lo);
    check("cmp_md_out", md_out, exp_md);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; order = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; order = OP_NOP; rs_val = 32'h0; rt_val = 32'h0;
  endtask

  task automatic wait_idle(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1'b1;
    end
    if (!done) check("wait_idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string name, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, a, b);
    wait_idle(n);
    check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  typedef struct packed {
    logic [6:0]  op;
    logic [31:0] a, b, h, l;
  } vec_t;
  vec_t vecs [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    vecs[0] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[1] = '{OP_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2] = '{OP_MULTU, 32'hffff_ffff, 32'h0000_0002, 32'h0000_0001, 32'hffff_fffe};
    vecs[3] = '{OP_MULT,  32'h7fff_ffff, 32'h8000_0000, 32'hc000_0000, 32'h8000_0000};

    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg", OP_MULT, 32'hffff_fffe, 32'd3, 5, 32'hffff_ffff, 32'hffff_fffa);
    run_op("multu_max", OP_MULTU, 32'hffff_ffff, 32'hffff_ffff, 5, 32'hffff_fffe, 32'h0000_0001);

    if (DIV_ON) begin
      run_op("div_neg", OP_DIV, 32'hffff_fff9, 32'd2, 10, 32'hffff_ffff, 32'hffff_fffd);
      run_op("div_negdvs", OP_DIV, 32'd7, 32'hffff_fffe, 10, 32'h0000_0001, 32'hffff_fffd);
      run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 10, 32'd100, 32'hffff_ffff);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hffff_ffff, 10, 32'h0, 32'h8000_0000);
      run_op("divu_big", OP_DIVU, 32'hffff_fff9, 32'd2, 10, 32'h1, 32'h7fff_fffc);
    end else begin
      run_op("div_off", OP_DIV, 32'hffff_fff9, 32'd2, 0, 32'hffff_fffe, 32'h0000_0001);
      run_op("divu_off", OP_DIVU, 32'd100, 32'd0, 0, 32'hffff_fffe, 32'h0000_0001);
    end

    // mthi, then mflo / mfhi reads served combinationally
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    check("mthi_hi", hi, 32'h1234_5678);
    start = 1'b1; order = OP_MFLO; #1;
    check("mflo_md", md_out, DIV_ON ? 32'h7fff_fffc : 32'h0000_0001);
    @(posedge clk); #1;
    order = OP_MFHI; #1;
    check("mfhi_md", md_out, 32'h1234_5678);
    @(posedge clk); #1;
    start = 1'b0; order = OP_NOP;
    check("mf_no_state_change", hi, 32'h1234_5678);

    issue(OP_MTLO, 32'hcafe_f00d, 32'h0);
    check("mtlo_lo", lo, 32'hcafe_f00d);
    check("mtlo_hi_kept", hi, 32'h1234_5678);

    // second mult while busy must be ignored
    issue(OP_MULT, 32'd3, 32'd4);
    issue(OP_MULT, 32'd5, 32'd6);
    wait_idle(n);
    check("ignore_cycles", 32'(n), 32'd4);
    check("ignore_hi", hi, 32'h0);
    check("ignore_lo", lo, 32'd12);

    for (int i = 0; i < 4; i++)
      run_op($sformatf("mult_vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5,
             vecs[i].h, vecs[i].l);

    // reset pulsed mid-operation
    issue(OP_MULT, 32'd7, 32'd9);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_commit_hi", hi, 32'h0);
    check("abort_no_commit_lo", lo, 32'h0);
    check("abort_no_commit_busy", {31'h0, busy}, 32'h0);

    run_op("post_reset_mult", OP_MULT, 32'd7, 32'd9, 5, 32'h0, 32'd63);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the E stage of the five-stage MIPS core, directly downstream of the instruction decoder. Consumes the decoder's 7-bit `order` code for mult, multu, div, divu, mthi, mtlo, mfhi and mflo. Holds the HI/LO register pair and runs a fixed-latency busy counter that models multi-cycle arithmetic. The hazard unit uses its `busy` output to stall the D stage.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  E-stage instruction valid this cycle
- order  in  7  decoded instruction code (CONST.v encoding)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  registered; high while an operation is in flight
- hi  out  32  HI register contents
- lo  out  32  LO register contents
- md_out  out  32  combinational: `hi` when order=`mfhi`, `lo` when order=`mflo`, else 0

## Operation
- Reset (reset=0, async): hi=0, lo=0, busy=0, counter=0, pending result cleared.
- Idle (busy=0), rising edge with start=1:
  - mult/multu: latch the signed/unsigned 64-bit product of rs_val×rt_val into a pending register; counter←MULT_CYCLES.
  - div/divu: latch quotient→pending LO and remainder→pending HI; signed division truncates toward zero, and the remainder takes the sign of the dividend. Counter←DIV_CYCLES.
  - mthi: hi←rs_val. mtlo: lo←rs_val. Both take effect at the same edge, with no busy cycles.
  - mfhi/mflo: no state change; the read is served by md_out.
  - Any other order: no effect.
- Busy: counter decrements by 1 each edge. On the edge where it goes 1→0, {hi,lo}←pending.
- busy = (counter ≠ 0), taken from a register.
- start=1 while busy=1 is ignored: no state change, and the in-flight operation continues. The hazard unit must stall the D stage on (start & MD order) | busy, so this case never arises in correct operation.
- Divide by zero (rt_val=0): pending LO=32'hFFFF_FFFF, pending HI=rs_val. Latency is unchanged.
- Signed overflow (div of 32'h8000_0000 by 32'hFFFF_FFFF): LO=32'h8000_0000, HI=0.
- Product width: the full 64 bits are kept. HI=[63:32], LO=[31:0].

## Timing
- An op accepted at edge T keeps busy high during cycles T+1 … T+N, where N is the configured latency.
- hi/lo show the new value from edge T+N onward. busy falls at that same edge.
- mthi/mtlo are visible one edge after acceptance.
- mfhi/mflo issued while busy=0 read the committed value combinationally in the same cycle.
- reset asserted mid-operation aborts it immediately. After release: busy=0, hi=lo=0, and the aborted result is never committed.

## Configuration
- MDU_DIV_EN defined: div/divu are supported as described above.
- MDU_DIV_EN undefined:
  - div/divu are treated as no-ops: no busy cycles, HI/LO unchanged.
  - The divider logic is not synthesized and DIV_CYCLES is unused.
  - mult/multu/mthi/mtlo/mfhi/mflo behave identically in both builds.

## Test plan
- mult rs=32'hFFFF_FFFE (−2), rt=3 → busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- multu rs=32'hFFFF_FFFF, rt=32'hFFFF_FFFF → hi=32'hFFFF_FFFE, lo=32'h0000_0001 after 5 busy cycles.
- div rs=−7 (32'hFFFF_FFF9), rt=2 → after 10 busy cycles lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. With MDU_DIV_EN undefined: busy stays 0 and hi/lo are unchanged.
- divu rs=100, rt=0 → lo=32'hFFFF_FFFF, hi=100.
- mthi rs=32'h1234_5678, then mflo/mfhi in the following cycles → md_out=lo, then 32'h1234_5678. A second mult asserted with start while busy is ignored, and the original result commits.
- mult accepted, reset pulsed low at cycle T+2 → busy=0 immediately, hi=lo=0, and no later commit.
